// File: rtl/running_min_ctrl.sv
// Issues candidate leaf indices for one query job and emits time-aligned running-minimum strobes.
// Optional perf counters are enabled by defining RUNNING_MIN_CTRL_PERF_EN.
`timescale 1ns/1ps
module running_min_ctrl #(
  parameter int PIPE_LAT = 2,
  parameter int IDX_W    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [IDX_W-1:0] start_leaf_base,
  input  logic [IDX_W:0]   start_leaf_count,
  input  logic             start_query_last,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [IDX_W-1:0] issue_leaf_idx,
  output logic             rm_valid,
  output logic             rm_restart,
  output logic             rm_query_last,
  input  logic             rm_valid_out,
  output logic             busy,
  output logic             done
`ifdef RUNNING_MIN_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_busy_cycles,
  output logic [31:0]      perf_stall_cycles
`endif
);

  localparam logic [IDX_W:0] MAX_CNT = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] ONE     = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0] ZERO    = '0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state;
  logic [IDX_W:0]      count;
  logic [IDX_W:0]      issued;
  logic [IDX_W:0]      retired;
  logic                qlast;
  logic [PIPE_LAT-1:0] tok_vld;
  logic [PIPE_LAT-1:0] tok_first;
  logic [PIPE_LAT-1:0] tok_last;

  logic                accept;
  logic                last_issue;
  logic [IDX_W:0]      cnt_sat;

  assign accept     = issue_valid & issue_ready;
  assign last_issue = accept && ((issued + ONE) == count);
  assign cnt_sat    = (start_leaf_count > MAX_CNT) ? MAX_CNT : start_leaf_count;

  assign rm_valid      = tok_vld[PIPE_LAT-1];
  assign rm_restart    = tok_first[PIPE_LAT-1];
  assign rm_query_last = tok_last[PIPE_LAT-1] & qlast;

  // Token line shifts every cycle so a token's latency is fixed regardless of later stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_vld   <= '0;
      tok_first <= '0;
      tok_last  <= '0;
    end else begin
      tok_vld[0]   <= accept;
      tok_first[0] <= accept && (issued == ZERO);
      tok_last[0]  <= last_issue;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tok_vld[i]   <= tok_vld[i-1];
        tok_first[i] <= tok_first[i-1];
        tok_last[i]  <= tok_last[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      issued         <= '0;
      retired        <= '0;
      qlast          <= 1'b0;
      start_ready    <= 1'b1;
      issue_valid    <= 1'b0;
      issue_leaf_idx <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            count          <= cnt_sat;
            qlast          <= start_query_last;
            issued         <= '0;
            retired        <= '0;
            issue_leaf_idx <= start_leaf_base;
            start_ready    <= 1'b0;
            busy           <= 1'b1;
            if (cnt_sat == ZERO) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= ISSUE;
              issue_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Retires can overlap issue when the job is longer than the pipeline.
          if (rm_valid_out) retired <= retired + ONE;
          if (accept) begin
            issued         <= issued + ONE;
            issue_leaf_idx <= issue_leaf_idx + 1'b1;
          end
          if (last_issue) begin
            state       <= DRAIN;
            issue_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (rm_valid_out) begin
            retired <= retired + ONE;
            if ((retired + ONE) == count) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUNNING_MIN_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && (perf_busy_cycles != 32'hFFFF_FFFF))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (issue_valid && !issue_ready && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_running_min_ctrl.sv
// Directed bench for running_min_ctrl; the datapath model echoes rm_valid back as rm_valid_out one cycle later.
`timescale 1ns/1ps
module tb_running_min_ctrl;
  localparam int IDX_W = 9;
  localparam int PL    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [IDX_W-1:0] start_leaf_base = '0;
  logic [IDX_W:0]   start_leaf_count = '0;
  logic             start_query_last = 1'b0;
  logic             issue_valid;
  logic             issue_ready = 1'b1;
  logic [IDX_W-1:0] issue_leaf_idx;
  logic             rm_valid;
  logic             rm_restart;
  logic             rm_query_last;
  logic             rm_valid_out = 1'b0;
  logic             busy;
  logic             done;
`ifdef RUNNING_MIN_CTRL_PERF_EN
  logic [31:0]      perf_busy_cycles;
  logic [31:0]      perf_stall_cycles;
  logic [31:0]      pb0, ps0;
`endif

  running_min_ctrl #(.PIPE_LAT(PL), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .start_leaf_base  (start_leaf_base),
    .start_leaf_count (start_leaf_count),
    .start_query_last (start_query_last),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_leaf_idx   (issue_leaf_idx),
    .rm_valid         (rm_valid),
    .rm_restart       (rm_restart),
    .rm_query_last    (rm_query_last),
    .rm_valid_out     (rm_valid_out),
    .busy             (busy),
    .done             (done)
`ifdef RUNNING_MIN_CTRL_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle logs; cycle 0 is the cycle in which the start is offered.
  logic [31:0]      m_iv, m_rv, m_rr, m_rq, m_done, m_sr, m_busy;
  logic [IDX_W-1:0] idx_log [0:31];
  int               first_done, n_rv, n_acc;

  task automatic run_job(input logic [IDX_W-1:0] base, input logic [IDX_W:0] cnt,
                         input logic ql, input logic [31:0] stall, input int ncyc);
    logic prev_rv;
    m_iv = '0; m_rv = '0; m_rr = '0; m_rq = '0; m_done = '0; m_sr = '0; m_busy = '0;
    first_done = -1; n_rv = 0; n_acc = 0;
    @(negedge clk);
    start_valid      = 1'b1;
    start_leaf_base  = base;
    start_leaf_count = cnt;
    start_query_last = ql;
    issue_ready      = !stall[0];
    rm_valid_out     = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 32) begin
        m_iv[c]   = issue_valid;
        m_rv[c]   = rm_valid;
        m_rr[c]   = rm_restart;
        m_rq[c]   = rm_query_last;
        m_done[c] = done;
        m_sr[c]   = start_ready;
        m_busy[c] = busy;
        idx_log[c] = issue_leaf_idx;
      end
      if (done && first_done < 0) first_done = c;
      if (rm_valid) n_rv++;
      if (issue_valid && issue_ready) n_acc++;
      prev_rv = rm_valid;
      @(negedge clk);
      start_valid  = 1'b0;
      issue_ready  = (c + 1 < 32) ? !stall[c+1] : 1'b1;
      rm_valid_out = prev_rv;
    end
    rm_valid_out = 1'b0;
    issue_ready  = 1'b1;
  endtask

  initial begin
    int saw_rv;
    #12;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_outputs", {issue_valid, issue_leaf_idx, rm_valid, rm_restart, rm_query_last, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Base 10, count 4, no stalls
`ifdef RUNNING_MIN_CTRL_PERF_EN
    pb0 = perf_busy_cycles;
`endif
    run_job(9'd10, 10'd4, 1'b0, 32'h0, 20);
    chk("t1_issue_valid", m_iv, 32'h1E);
    chk("t1_idx1", idx_log[1], 10);
    chk("t1_idx2", idx_log[2], 11);
    chk("t1_idx3", idx_log[3], 12);
    chk("t1_idx4", idx_log[4], 13);
    chk("t1_rm_valid", m_rv, 32'h78);
    chk("t1_restart", m_rr, 32'h08);
    chk("t1_qlast", m_rq, 32'h0);
    chk("t1_done", m_done, 32'h100);
    chk("t1_start_ready", m_sr[9:0], 10'b10_0000_0001);
    chk("t1_busy", m_busy[9:0], 10'b01_1111_1110);
`ifdef RUNNING_MIN_CTRL_PERF_EN
    chk("t1_perf_busy", perf_busy_cycles - pb0, 8);
`endif

    // Index wrap at 2^IDX_W
    run_job(9'd510, 10'd4, 1'b0, 32'h0, 20);
    chk("t2_idx1", idx_log[1], 510);
    chk("t2_idx2", idx_log[2], 511);
    chk("t2_idx3", idx_log[3], 0);
    chk("t2_idx4", idx_log[4], 1);
    chk("t2_done", m_done, 32'h100);

    // Stall in cycles 2..3
`ifdef RUNNING_MIN_CTRL_PERF_EN
    ps0 = perf_stall_cycles;
`endif
    run_job(9'd10, 10'd4, 1'b0, 32'hC, 20);
    chk("t3_issue_valid", m_iv, 32'h7E);
    chk("t3_idx2", idx_log[2], 11);
    chk("t3_idx3", idx_log[3], 11);
    chk("t3_idx4", idx_log[4], 11);
    chk("t3_idx6", idx_log[6], 13);
    chk("t3_rm_valid", m_rv, 32'h1C8);
    chk("t3_done", m_done, 32'h400);
`ifdef RUNNING_MIN_CTRL_PERF_EN
    chk("t3_perf_stall", perf_stall_cycles - ps0, 2);
`endif

    // Count 1, final batch
    run_job(9'd7, 10'd1, 1'b1, 32'h0, 12);
    chk("t4_rm_valid", m_rv, 32'h08);
    chk("t4_restart", m_rr, 32'h08);
    chk("t4_qlast", m_rq, 32'h08);
    chk("t4_done", m_done, 32'h20);

    // Count 5, final batch: query_last only on the last token
    run_job(9'd100, 10'd5, 1'b1, 32'h0, 16);
    chk("t5_rm_valid", m_rv, 32'hF8);
    chk("t5_restart", m_rr, 32'h08);
    chk("t5_qlast", m_rq, 32'h80);
    chk("t5_done", m_done, 32'h200);

    // Count 0
    run_job(9'd3, 10'd0, 1'b1, 32'h0, 8);
    chk("t6_issue_valid", m_iv, 32'h0);
    chk("t6_rm_valid", m_rv, 32'h0);
    chk("t6_done", m_done, 32'h2);
    chk("t6_start_ready", m_sr[2:0], 3'b101);
    chk("t6_busy", m_busy[2:0], 3'b010);

    // Count above 2^IDX_W saturates to 512
    run_job(9'd0, 10'h3FF, 1'b0, 32'h0, 530);
    chk("t7_done_cycle", first_done, 516);
    chk("t7_accepts", n_acc, 512);
    chk("t7_rm_valids", n_rv, 512);

    // Reset mid-ISSUE of a count-8 job
    @(negedge clk);
    start_valid = 1'b1; start_leaf_base = 9'd40; start_leaf_count = 10'd8; start_query_last = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_start_ready", start_ready, 1);
    chk("t8_rst_outputs", {issue_valid, issue_leaf_idx, rm_valid, rm_restart, rm_query_last, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_rv = 0;
    for (int c = 0; c < 12; c++) begin
      if (rm_valid || issue_valid || done) saw_rv++;
      @(negedge clk);
    end
    chk("t8_quiet_after_reset", saw_rv, 0);
    run_job(9'd20, 10'd2, 1'b0, 32'h0, 12);
    chk("t8_idx1", idx_log[1], 20);
    chk("t8_idx2", idx_log[2], 21);
    chk("t8_rm_valid", m_rv, 32'h18);
    chk("t8_done", m_done, 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
